// File: rtl/carfield_dyn_addr_map.sv
// rtl/carfield_dyn_addr_map.sv - run-time reprogrammable address decoder with shadow table and drained commit
//
// Decodes a lookup address against NumRules [start, end) regions; the lowest
// enabled matching rule supplies the target index, a miss returns DefaultIdx.
// Software edits a shadow table; a commit waits until every decoded transaction
// has completed, then copies shadow to active in a single cycle.
//
// Optional feature macro: CARFIELD_ADDR_MAP_LOCK_EN adds lock_i / locked_o, a
// sticky lock that freezes the map until reset.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   cfg_valid_i/cfg_ready_o           shadow-table write handshake
//   cfg_rule_i, cfg_start_i/end_i,
//   cfg_idx_i, cfg_en_i               rule number, region, target index, enable
//   commit_i/commit_done_o            commit request, one-cycle done pulse
//   addr_valid_i/addr_ready_o/addr_i  lookup request
//   dec_valid_o/dec_ready_i,
//   dec_hit_o/dec_idx_o               registered decode result
//   txn_done_i                        one decoded transaction completed
//   lock_i/locked_o                   (lock build only) sticky map lock
//   outstanding_o, busy_o             in-flight count, commit in progress
module carfield_dyn_addr_map #(
  parameter int NumRules       = 5,
  parameter int AddrWidth      = 48,
  parameter int IdxWidth       = 3,
  parameter int MaxOutstanding = 8,
  parameter int DefaultIdx     = 0,
  parameter int RuleWidth      = (NumRules > 1) ? $clog2(NumRules) : 1,
  parameter int OutWidth       = $clog2(MaxOutstanding + 1),
  // rule 4..0: integer cluster, mailbox, safety island, L2 port 2, L2 port 1
  parameter logic [NumRules-1:0][AddrWidth-1:0] RstStart = {
    48'h0000_5000_0000, 48'h0000_4000_0000, 48'h0000_6000_0000,
    48'h0000_7820_0000, 48'h0000_7800_0000},
  parameter logic [NumRules-1:0][AddrWidth-1:0] RstEnd = {
    48'h0000_5080_0000, 48'h0000_4000_1000, 48'h0000_6080_0000,
    48'h0000_7840_0000, 48'h0000_7820_0000},
  parameter logic [NumRules-1:0][IdxWidth-1:0] RstIdx = {
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter logic [NumRules-1:0] RstEn = 5'b11111
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [RuleWidth-1:0] cfg_rule_i,
  input  logic [AddrWidth-1:0] cfg_start_i,
  input  logic [AddrWidth-1:0] cfg_end_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic                 cfg_en_i,
  input  logic                 commit_i,
  output logic                 commit_done_o,
  input  logic                 addr_valid_i,
  output logic                 addr_ready_o,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic                 dec_hit_o,
  output logic [IdxWidth-1:0]  dec_idx_o,
  input  logic                 txn_done_i,
`ifdef CARFIELD_ADDR_MAP_LOCK_EN
  input  logic                 lock_i,
  output logic                 locked_o,
`endif
  output logic [OutWidth-1:0]  outstanding_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {Idle, Drain, Commit} state_t;

  state_t stateQ, stateD;

  logic [AddrWidth-1:0] actStart [NumRules];
  logic [AddrWidth-1:0] actEnd   [NumRules];
  logic [IdxWidth-1:0]  actIdx   [NumRules];
  logic                 actEn    [NumRules];
  logic [AddrWidth-1:0] shdStart [NumRules];
  logic [AddrWidth-1:0] shdEnd   [NumRules];
  logic [IdxWidth-1:0]  shdIdx   [NumRules];
  logic                 shdEn    [NumRules];

  logic                locked;
  logic                cfgFire, addrFire, decFire, doneDec;
  logic                lookupHit;
  logic [IdxWidth-1:0] lookupIdx;
  logic [OutWidth:0]   effCount;

`ifdef CARFIELD_ADDR_MAP_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked <= 1'b0;
    end else if (lock_i && stateQ == Idle) begin
      locked <= 1'b1;
    end
  end
  assign locked_o = locked;
`else
  assign locked = 1'b0;
`endif

  assign cfg_ready_o   = (stateQ == Idle) && !locked;
  assign commit_done_o = (stateQ == Commit);
  assign busy_o        = (stateQ != Idle);

  // The result currently leaving the output register is counted too, so the
  // in-flight counter can never be pushed past MaxOutstanding.
  assign effCount     = {1'b0, outstanding_o} + {{OutWidth{1'b0}}, dec_valid_o};
  assign addr_ready_o = (stateQ == Idle) && (!dec_valid_o || dec_ready_i) &&
                        (effCount < (OutWidth+1)'(MaxOutstanding));

  assign cfgFire  = cfg_valid_i && cfg_ready_o;
  assign addrFire = addr_valid_i && addr_ready_o;
  assign decFire  = dec_valid_o && dec_ready_i;
  assign doneDec  = txn_done_i && (outstanding_o != '0);

  // Descending scan so the lowest-numbered matching rule has the last word.
  always_comb begin
    lookupHit = 1'b0;
    lookupIdx = IdxWidth'(DefaultIdx);
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (actEn[r] && (addr_i >= actStart[r]) && (addr_i < actEnd[r])) begin
        lookupHit = 1'b1;
        lookupIdx = actIdx[r];
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      Idle:    if (commit_i && !locked) stateD = Drain;
      Drain:   if (outstanding_o == '0 && !dec_valid_o) stateD = Commit;
      Commit:  stateD = Idle;
      default: stateD = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ <= Idle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else if (decFire && !doneDec) begin
      outstanding_o <= outstanding_o + OutWidth'(1);
    end else if (doneDec && !decFire) begin
      outstanding_o <= outstanding_o - OutWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o <= 1'b0;
      dec_hit_o   <= 1'b0;
      dec_idx_o   <= IdxWidth'(DefaultIdx);
    end else if (addrFire) begin
      dec_valid_o <= 1'b1;
      dec_hit_o   <= lookupHit;
      dec_idx_o   <= lookupIdx;
    end else if (decFire) begin
      dec_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRules; r++) begin
        actStart[r] <= RstStart[r];
        actEnd[r]   <= RstEnd[r];
        actIdx[r]   <= RstIdx[r];
        actEn[r]    <= RstEn[r];
        shdStart[r] <= RstStart[r];
        shdEnd[r]   <= RstEnd[r];
        shdIdx[r]   <= RstIdx[r];
        shdEn[r]    <= RstEn[r];
      end
    end else begin
      for (int r = 0; r < NumRules; r++) begin
        if (cfgFire && int'(cfg_rule_i) == r) begin
          shdStart[r] <= cfg_start_i;
          shdEnd[r]   <= cfg_end_i;
          shdIdx[r]   <= cfg_idx_i;
          shdEn[r]    <= cfg_en_i;
        end
        if (stateQ == Commit) begin
          actStart[r] <= shdStart[r];
          actEnd[r]   <= shdEnd[r];
          actIdx[r]   <= shdIdx[r];
          actEn[r]    <= shdEn[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_carfield_dyn_addr_map.sv
// tb/tb_carfield_dyn_addr_map.sv - directed self-checking bench for carfield_dyn_addr_map
module tb_carfield_dyn_addr_map;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        cfgValid = 1'b0;
  logic        cfgReady;
  logic [2:0]  cfgRule = '0;
  logic [47:0] cfgStart = '0;
  logic [47:0] cfgEnd = '0;
  logic [2:0]  cfgIdx = '0;
  logic        cfgEn = 1'b0;
  logic        commit = 1'b0;
  logic        commitDone;
  logic        addrValid = 1'b0;
  logic        addrReady;
  logic [47:0] addr = '0;
  logic        decValid;
  logic        decReady = 1'b1;
  logic        decHit;
  logic [2:0]  decIdx;
  logic        txnDone = 1'b0;
  logic [3:0]  outstanding;
  logic        busy;
`ifdef CARFIELD_ADDR_MAP_LOCK_EN
  logic        lock = 1'b0;
  logic        locked;
`endif

  int checks = 0;
  int errors = 0;

  carfield_dyn_addr_map dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .cfg_valid_i   (cfgValid),
    .cfg_ready_o   (cfgReady),
    .cfg_rule_i    (cfgRule),
    .cfg_start_i   (cfgStart),
    .cfg_end_i     (cfgEnd),
    .cfg_idx_i     (cfgIdx),
    .cfg_en_i      (cfgEn),
    .commit_i      (commit),
    .commit_done_o (commitDone),
    .addr_valid_i  (addrValid),
    .addr_ready_o  (addrReady),
    .addr_i        (addr),
    .dec_valid_o   (decValid),
    .dec_ready_i   (decReady),
    .dec_hit_o     (decHit),
    .dec_idx_o     (decIdx),
    .txn_done_i    (txnDone),
`ifdef CARFIELD_ADDR_MAP_LOCK_EN
    .lock_i        (lock),
    .locked_o      (locked),
`endif
    .outstanding_o (outstanding),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!addrReady && n < 20) begin
      tick();
      n++;
    end
    checkVal({tag, "_rdy"}, addrReady, 1);
  endtask

  // One lookup, result checked the cycle after acceptance; left outstanding.
  task automatic lookupHold(input string tag, input logic [47:0] a,
                            input logic expHit, input logic [2:0] expIdx);
    waitReady(tag);
    addrValid = 1'b1;
    addr = a;
    tick();
    addrValid = 1'b0;
    checkVal({tag, "_vld"}, decValid, 1);
    checkVal({tag, "_hit"}, decHit, expHit);
    checkVal({tag, "_idx"}, decIdx, expIdx);
    tick();
  endtask

  task automatic lookup(input string tag, input logic [47:0] a,
                        input logic expHit, input logic [2:0] expIdx);
    lookupHold(tag, a, expHit, expIdx);
    txnDone = 1'b1;
    tick();
    txnDone = 1'b0;
  endtask

  task automatic cfgWrite(input logic [2:0] r, input logic [47:0] s, input logic [47:0] e,
                          input logic [2:0] idx, input logic en);
    cfgValid = 1'b1;
    cfgRule = r;
    cfgStart = s;
    cfgEnd = e;
    cfgIdx = idx;
    cfgEn = en;
    tick();
    cfgValid = 1'b0;
  endtask

  task automatic doCommit(input string tag);
    int n = 0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    while (!commitDone && n < 10) begin
      tick();
      n++;
    end
    checkVal({tag, "_done"}, commitDone, 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rstN = 1'b1;
    checkVal("rst_outstanding", outstanding, 0);
    checkVal("rst_dec_valid", decValid, 0);
    checkVal("rst_dec_hit", decHit, 0);
    checkVal("rst_dec_idx", decIdx, 0);
    checkVal("rst_commit_done", commitDone, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_cfg_ready", cfgReady, 1);
    checkVal("rst_addr_ready", addrReady, 1);

    lookup("l2p2", 48'h7820_0010, 1'b1, 3'd1);
    lookup("l2p1", 48'h7800_0000, 1'b1, 3'd0);
    lookup("miss", 48'h9000_0000, 1'b0, 3'd0);
    lookup("mbox_last", 48'h4000_0FFF, 1'b1, 3'd3);
    lookup("mbox_end", 48'h4000_1000, 1'b0, 3'd0);

    // Eight back-to-back lookups with no completions fill the in-flight budget.
    addrValid = 1'b1;
    addr = 48'h6000_0040;
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("burst_rdy%0d", i), addrReady, 1);
      tick();
    end
    addrValid = 1'b0;
    tick();
    checkVal("full_outstanding", outstanding, 8);
    checkVal("full_rdy", addrReady, 0);
    txnDone = 1'b1;
    tick();
    txnDone = 1'b0;
    checkVal("one_done_outstanding", outstanding, 7);
    checkVal("one_done_rdy", addrReady, 1);
    txnDone = 1'b1;
    repeat (7) tick();
    txnDone = 1'b0;
    checkVal("empty_outstanding", outstanding, 0);

    // Commit with three transactions still in flight.
    cfgWrite(3'd4, 48'h5000_0000, 48'h5100_0000, 3'd6, 1'b1);
    for (int i = 0; i < 3; i++) lookupHold("old_tbl", 48'h5090_0000, 1'b0, 3'd0);
    checkVal("pre_commit_outstanding", outstanding, 3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("drain_busy%0d", i), busy, 1);
      checkVal($sformatf("drain_rdy%0d", i), addrReady, 0);
      checkVal($sformatf("drain_cfg_rdy%0d", i), cfgReady, 0);
      checkVal($sformatf("drain_done%0d", i), commitDone, 0);
      txnDone = 1'b1;
      tick();
      txnDone = 1'b0;
    end
    checkVal("drained_done", commitDone, 0);
    tick();
    checkVal("commit_done", commitDone, 1);
    checkVal("commit_busy", busy, 1);
    tick();
    checkVal("after_done", commitDone, 0);
    checkVal("after_busy", busy, 0);
    lookup("new_tbl", 48'h5090_0000, 1'b1, 3'd6);

    // Overlap resolution and an empty region.
    cfgWrite(3'd0, 48'h6000_0000, 48'h6010_0000, 3'd5, 1'b1);
    cfgWrite(3'd3, 48'h4000_0000, 48'h4000_0000, 3'd3, 1'b1);
    lookup("shadow_only", 48'h6000_0000, 1'b1, 3'd2);
    doCommit("ovl_commit");
    lookup("overlap", 48'h6000_0000, 1'b1, 3'd5);
    lookup("overlap_out", 48'h6050_0000, 1'b1, 3'd2);
    lookup("empty_rule", 48'h4000_0000, 1'b0, 3'd0);
    lookup("rule0_moved", 48'h7800_0010, 1'b0, 3'd0);

`ifdef CARFIELD_ADDR_MAP_LOCK_EN
    lock = 1'b1;
    tick();
    lock = 1'b0;
    checkVal("locked", locked, 1);
    checkVal("lock_cfg_rdy", cfgReady, 0);
    cfgWrite(3'd0, 48'h6000_0000, 48'h6010_0000, 3'd7, 1'b1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (commitDone) seen = 1'b1;
        tick();
      end
      checkVal("lock_no_commit", seen, 0);
    end
    checkVal("lock_busy", busy, 0);
    lookup("lock_tbl", 48'h6000_0000, 1'b1, 3'd5);
`endif

    // Reset restores the power-on map in both tables.
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
`ifdef CARFIELD_ADDR_MAP_LOCK_EN
    checkVal("rst_unlocked", locked, 0);
`endif
    lookup("rst_rule0", 48'h7800_0010, 1'b1, 3'd0);
    lookup("rst_rule4", 48'h5090_0000, 1'b0, 3'd0);
    doCommit("rst_commit");
    lookup("rst_shadow", 48'h4000_0000, 1'b1, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
